cfi_shadow_stack: RTL and testbench
===================================

Name: cfi_shadow_stack

Overview:
Hardware shadow return-address stack that owns the buffer read by the ALU/branch-unit check path in the execute stage.
- Commit logic pushes the return address of every committed call.
- The branch unit submits a check for every return and receives a registered ok/violation.
- A combinational indexed read port serves read_index/read_out/data_in_buffer.
- A sticky crash output feeds the core's to_crash path.

Parameters:
DEPTH, 16, number of return-address entries; power of two, 2..1024
AW, 32, width of a stored address (riscv::VLEN)
IDXW, 20, width of the read index port

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  context flush; empties stack, keeps sticky flags
enable_i  in  1  CFI active; when low, pushes and checks are ignored
push_valid_i  in  1  committed call; push push_addr_i
push_addr_i  in  AW  return address (call PC + 2/4)
chk_valid_i  in  1  return being resolved; pop and compare
chk_addr_i  in  AW  actual return target
chk_done_o  out  1  check response valid (1 cycle after chk_valid_i)
chk_ok_o  out  1  target matched (qualified by chk_done_o)
read_index_i  in  IDXW  entry index; 0 = top of stack
read_out_o  out  32  entry at read_index_i, zero-extended/truncated to 32
data_in_buffer_o  out  1  read_index_i < count
count_o  out  $clog2(DEPTH)+1  valid entries
overflow_o  out  1  sticky: a push occurred while full
to_crash_o  out  1  sticky violation

Behaviour:
- Reset values: count = 0; top = 0; all entries = 0; state = IDLE. All outputs = 0.
- Storage: circular array indexed by top, with 0..DEPTH saturating count. Push writes entry[top] and advances top (mod DEPTH).
- Push:
  - count < DEPTH: count + 1.
  - count == DEPTH: oldest entry overwritten, count unchanged, overflow_o set.
- Check with count > 0:
  - Compare chk_addr_i against entry[top-1]; pop (top-1 mod DEPTH, count-1).
  - Result registered: chk_done_o = 1 next cycle, chk_ok_o = equality.
- Check with count == 0: behaviour set by the optional feature; no pop.
- Push and check in the same cycle:
  - Check and pop happen first against the current top.
  - Push then writes into the freed slot.
  - Net count unchanged; the top entry is replaced by push_addr_i.
  - With count == 0, the check is treated as empty and the push proceeds.
- Read port:
  - Combinational: read_out_o = entry[(top-1-read_index_i) mod DEPTH] when data_in_buffer_o, else 0.
  - Reflects state before the current cycle's push/pop.
- FSM:
  - IDLE: no response pending. On chk_valid_i, go to RESP.
  - RESP: chk_done_o = 1.
    - Mismatch goes to CRASHED.
    - A new chk_valid_i stays in RESP; back-to-back checks are accepted every cycle.
    - Otherwise return to IDLE.
  - CRASHED: to_crash_o = 1; all pushes and checks ignored; chk_done_o = 0. Left only by rst_ni; flush_i does not clear it.
- flush_i:
  - count and top go to 0.
  - Any pending response is dropped: chk_done_o = 0 next cycle, state IDLE unless CRASHED.
  - Takes priority over a simultaneous push/check.
- enable_i low: push/check ignored; an already-pending response still completes.
- Reset mid-operation: asynchronous return to reset values, including any pending response.

Optional Feature:
CFI_STRICT_UNDERFLOW_EN
- Defined: a check on an empty stack reports chk_ok_o = 0 and enters CRASHED.
- Undefined: a check on an empty stack reports chk_ok_o = 1. This tolerates entries lost to overflow or a prior flush.

Decomposition:
- cfi_pkg holds:
  - typedef ss_entry_t (logic [AW-1:0])
  - enum ss_state_e {IDLE, RESP, CRASHED}
  - constant SS_DEPTH_DEFAULT = 16
- One sub-module, cfi_ss_mem: circular array with top pointer, push/pop ports, and the combinational indexed read. The parent keeps count, the FSM, compare and sticky flags.

Test Plan:
1. Push 0x8000_0010, push 0x8000_0024; check 0x8000_0024 -> next cycle chk_done_o = 1, chk_ok_o = 1, count_o = 1, read_index 0 gives 0x8000_0010.
2. Push 0x100; check 0x104 -> chk_ok_o = 0, to_crash_o = 1 and held; a following push 0x200 leaves count_o = 0 (ignored).
3. DEPTH = 16: push 0x1000..0x1044 (18 pushes) -> count_o = 16, overflow_o = 1, read index 15 = 0x1008, index 16 gives data_in_buffer_o = 0 and read_out_o = 0.
4. With count 2 (top 0xA0): simultaneous check 0xA0 and push 0xB0 -> chk_ok_o = 1, count_o = 2, index 0 = 0xB0.
5. Empty stack, check 0x44 -> chk_ok_o = 1 without macro; chk_ok_o = 0 and to_crash_o = 1 with CFI_STRICT_UNDERFLOW_EN.
6. Push 3 entries, check issued, flush_i in the response cycle -> count_o = 0, chk_done_o = 0 next cycle; assert rst_ni = 0 while CRASHED -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/cfi_pkg.sv
// Shared types and constants for the CFI shadow return-address stack.
package cfi_pkg;

    localparam int SS_DEPTH_DEFAULT = 16;
    localparam int SS_AW_DEFAULT    = 32;

    typedef logic [SS_AW_DEFAULT-1:0] ss_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        RESP,
        CRASHED
    } ss_state_e;

endpackage

// File: rtl/cfi_ss_mem.sv
// Circular return-address array with top pointer, push/pop and indexed read.
module cfi_ss_mem
    import cfi_pkg::*;
#(
    parameter  int DEPTH = SS_DEPTH_DEFAULT,
    parameter  int AW    = SS_AW_DEFAULT,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [AW-1:0] wdata_i,
    input  logic [PW-1:0] rd_idx_i,
    output logic [AW-1:0] top_data_o,
    output logic [AW-1:0] rd_data_o
);

    logic [AW-1:0] mem_q [DEPTH];
    logic [PW-1:0] top_q;
    logic [PW-1:0] top_m1;
    logic [PW-1:0] rd_ptr;

    assign top_m1     = top_q - PW'(1);
    assign rd_ptr     = top_m1 - rd_idx_i;
    assign top_data_o = mem_q[top_m1];
    assign rd_data_o  = mem_q[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            top_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            top_q <= '0;
        end else if (push_i && pop_i) begin
            // pop frees the top slot, push refills it in place
            mem_q[top_m1] <= wdata_i;
        end else if (push_i) begin
            mem_q[top_q] <= wdata_i;
            top_q        <= top_q + PW'(1);
        end else if (pop_i) begin
            top_q <= top_m1;
        end
    end

endmodule

// File: rtl/cfi_shadow_stack.sv
// Shadow return-address stack with registered check response and sticky crash.
// Optional CFI_STRICT_UNDERFLOW_EN: a check on an empty stack is a violation.
module cfi_shadow_stack
    import cfi_pkg::*;
#(
    parameter  int DEPTH = SS_DEPTH_DEFAULT,
    parameter  int AW    = 32,
    parameter  int IDXW  = 20,
    localparam int CW    = $clog2(DEPTH) + 1,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            enable_i,
    input  logic            push_valid_i,
    input  logic [AW-1:0]   push_addr_i,
    input  logic            chk_valid_i,
    input  logic [AW-1:0]   chk_addr_i,
    output logic            chk_done_o,
    output logic            chk_ok_o,
    input  logic [IDXW-1:0] read_index_i,
    output logic [31:0]     read_out_o,
    output logic            data_in_buffer_o,
    output logic [CW-1:0]   count_o,
    output logic            overflow_o,
    output logic            to_crash_o
);

`ifdef CFI_STRICT_UNDERFLOW_EN
    localparam logic EMPTY_OK = 1'b0;
`else
    localparam logic EMPTY_OK = 1'b1;
`endif

    ss_state_e     state_q;
    logic [CW-1:0] count_q;
    logic          done_q, ok_q, crash_q, ovf_q;
    logic          act, push, chk, pop;
    logic          empty, full, res_ok;
    logic [AW-1:0] top_data, rd_data;

    // a mismatch awaiting its crash transition blocks new work too
    assign act   = enable_i & ~flush_i & (state_q != CRASHED)
                 & ~((state_q == RESP) & ~ok_q);
    assign push  = act & push_valid_i;
    assign chk   = act & chk_valid_i;
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign pop   = chk & ~empty;

    assign res_ok = empty ? EMPTY_OK : (chk_addr_i == top_data);

    cfi_ss_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .push_i     (push),
        .pop_i      (pop),
        .wdata_i    (push_addr_i),
        .rd_idx_i   (read_index_i[PW-1:0]),
        .top_data_o (top_data),
        .rd_data_o  (rd_data)
    );

    assign data_in_buffer_o = 32'(read_index_i) < 32'(count_q);
    assign read_out_o       = data_in_buffer_o ? 32'(rd_data) : '0;
    assign count_o          = count_q;
    assign overflow_o       = ovf_q;
    assign chk_done_o       = done_q;
    assign chk_ok_o         = ok_q;
    assign to_crash_o       = crash_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (flush_i) begin
            count_q <= '0;
        end else if (push && !pop && !full) begin
            count_q <= count_q + CW'(1);
        end else if (push && !pop) begin
            ovf_q <= 1'b1;
        end else if (pop && !push) begin
            count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            crash_q <= 1'b0;
        end else begin
            unique case (state_q)
                CRASHED: begin
                    done_q <= 1'b0;
                    ok_q   <= 1'b0;
                end
                RESP: begin
                    if (!ok_q) begin
                        state_q <= CRASHED;
                        crash_q <= 1'b1;
                        done_q  <= 1'b0;
                    end else if (chk) begin
                        done_q <= 1'b1;
                        ok_q   <= res_ok;
                    end else begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                        ok_q    <= 1'b0;
                    end
                end
                default: begin
                    if (chk) begin
                        state_q <= RESP;
                        done_q  <= 1'b1;
                        ok_q    <= res_ok;
                    end else begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                        ok_q    <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfi_shadow_stack.sv
// Directed self-checking bench for cfi_shadow_stack (DEPTH 16).
module tb_cfi_shadow_stack;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        enable_i;
    logic        push_valid_i;
    logic [31:0] push_addr_i;
    logic        chk_valid_i;
    logic [31:0] chk_addr_i;
    logic        chk_done_o;
    logic        chk_ok_o;
    logic [19:0] read_index_i;
    logic [31:0] read_out_o;
    logic        data_in_buffer_o;
    logic [4:0]  count_o;
    logic        overflow_o;
    logic        to_crash_o;

    int checks = 0;
    int fails  = 0;

    always #5 clk_i = ~clk_i;

    cfi_shadow_stack dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .flush_i          (flush_i),
        .enable_i         (enable_i),
        .push_valid_i     (push_valid_i),
        .push_addr_i      (push_addr_i),
        .chk_valid_i      (chk_valid_i),
        .chk_addr_i       (chk_addr_i),
        .chk_done_o       (chk_done_o),
        .chk_ok_o         (chk_ok_o),
        .read_index_i     (read_index_i),
        .read_out_o       (read_out_o),
        .data_in_buffer_o (data_in_buffer_o),
        .count_o          (count_o),
        .overflow_o       (overflow_o),
        .to_crash_o       (to_crash_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_push(input logic [31:0] a);
        push_valid_i = 1'b1;
        push_addr_i  = a;
        tick();
        push_valid_i = 1'b0;
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        tick();
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        #7;
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        flush_i = 0; enable_i = 1; push_valid_i = 0; push_addr_i = 0;
        chk_valid_i = 0; chk_addr_i = 0; read_index_i = 0;
        rst_ni = 1'b0;
        #12;
        checks++;
        if (count_o !== 5'd0) begin
            fails++; $display("FAIL reset_count got %0d exp 0", count_o);
        end
        checks++;
        if ({chk_done_o, chk_ok_o, overflow_o, to_crash_o} !== 4'b0) begin
            fails++;
            $display("FAIL reset_flags got %b exp 0000",
                     {chk_done_o, chk_ok_o, overflow_o, to_crash_o});
        end
        checks++;
        if ({data_in_buffer_o, read_out_o} !== 33'd0) begin
            fails++;
            $display("FAIL reset_read got %b/%h exp 0/0",
                     data_in_buffer_o, read_out_o);
        end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        do_push(32'h8000_0010);
        do_push(32'h8000_0024);
        chk_valid_i = 1; chk_addr_i = 32'h8000_0024;
        tick();
        chk_valid_i = 0; read_index_i = 0;
        checks++;
        if ({chk_done_o, chk_ok_o} !== 2'b11) begin
            fails++; $display("FAIL basic_resp got %b exp 11", {chk_done_o, chk_ok_o});
        end
        checks++;
        if (count_o !== 5'd1) begin
            fails++; $display("FAIL basic_count got %0d exp 1", count_o);
        end
        checks++;
        if (read_out_o !== 32'h8000_0010) begin
            fails++; $display("FAIL basic_idx0 got %h exp 80000010", read_out_o);
        end
        tick();
        checks++;
        if (chk_done_o !== 1'b0) begin
            fails++; $display("FAIL basic_done_clear got %b exp 0", chk_done_o);
        end
    endtask

    task automatic test_same_cycle();
        do_push(32'hA0);
        chk_valid_i = 1; chk_addr_i = 32'hA0;
        push_valid_i = 1; push_addr_i = 32'hB0;
        tick();
        chk_valid_i = 0; push_valid_i = 0;
        checks++;
        if ({chk_done_o, chk_ok_o} !== 2'b11 || count_o !== 5'd2) begin
            fails++;
            $display("FAIL same_cycle got ok=%b cnt=%0d exp ok=11 cnt=2",
                     {chk_done_o, chk_ok_o}, count_o);
        end
        read_index_i = 0; #1;
        checks++;
        if (read_out_o !== 32'hB0) begin
            fails++; $display("FAIL same_cycle_idx0 got %h exp b0", read_out_o);
        end
        read_index_i = 1; #1;
        checks++;
        if (read_out_o !== 32'h8000_0010) begin
            fails++; $display("FAIL same_cycle_idx1 got %h exp 80000010", read_out_o);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        do_flush();
        do_push(32'h10); do_push(32'h20); do_push(32'h30);
        chk_valid_i = 1; chk_addr_i = 32'h30;
        tick();
        checks++;
        if ({chk_done_o, chk_ok_o} !== 2'b11 || count_o !== 5'd2) begin
            fails++;
            $display("FAIL b2b_first got %b cnt=%0d exp 11 cnt=2",
                     {chk_done_o, chk_ok_o}, count_o);
        end
        chk_addr_i = 32'h20;
        tick();
        chk_valid_i = 0;
        checks++;
        if ({chk_done_o, chk_ok_o} !== 2'b11 || count_o !== 5'd1) begin
            fails++;
            $display("FAIL b2b_second got %b cnt=%0d exp 11 cnt=1",
                     {chk_done_o, chk_ok_o}, count_o);
        end
        tick();
    endtask

    task automatic test_enable();
        enable_i = 0;
        do_push(32'h55);
        chk_valid_i = 1; chk_addr_i = 32'h10;
        tick();
        chk_valid_i = 0;
        checks++;
        if (count_o !== 5'd1 || chk_done_o !== 1'b0) begin
            fails++;
            $display("FAIL enable_low got cnt=%0d done=%b exp cnt=1 done=0",
                     count_o, chk_done_o);
        end
        enable_i = 1;
    endtask

    task automatic test_overflow();
        do_flush();
        for (int i = 0; i < 18; i++) do_push(32'h1000 + 32'(4 * i));
        checks++;
        if (count_o !== 5'd16 || overflow_o !== 1'b1) begin
            fails++;
            $display("FAIL ovf_state got cnt=%0d ovf=%b exp cnt=16 ovf=1",
                     count_o, overflow_o);
        end
        read_index_i = 0; #1;
        checks++;
        if (read_out_o !== 32'h1044) begin
            fails++; $display("FAIL ovf_idx0 got %h exp 1044", read_out_o);
        end
        read_index_i = 15; #1;
        checks++;
        if (read_out_o !== 32'h1008 || data_in_buffer_o !== 1'b1) begin
            fails++;
            $display("FAIL ovf_idx15 got %h/%b exp 1008/1", read_out_o, data_in_buffer_o);
        end
        read_index_i = 16; #1;
        checks++;
        if (read_out_o !== 32'h0 || data_in_buffer_o !== 1'b0) begin
            fails++;
            $display("FAIL ovf_idx16 got %h/%b exp 0/0", read_out_o, data_in_buffer_o);
        end
        read_index_i = 0;
    endtask

    task automatic test_flush();
        do_flush();
        checks++;
        if (overflow_o !== 1'b1 || count_o !== 5'd0) begin
            fails++;
            $display("FAIL flush_sticky got ovf=%b cnt=%0d exp ovf=1 cnt=0",
                     overflow_o, count_o);
        end
        do_push(32'h300); do_push(32'h304); do_push(32'h308);
        chk_valid_i = 1; chk_addr_i = 32'h308;
        tick();
        chk_valid_i = 0;
        checks++;
        if (chk_done_o !== 1'b1) begin
            fails++; $display("FAIL flush_pre_done got %b exp 1", chk_done_o);
        end
        flush_i = 1;
        tick();
        flush_i = 0;
        checks++;
        if (count_o !== 5'd0 || chk_done_o !== 1'b0) begin
            fails++;
            $display("FAIL flush_drop got cnt=%0d done=%b exp cnt=0 done=0",
                     count_o, chk_done_o);
        end
        flush_i = 1; push_valid_i = 1; push_addr_i = 32'h400;
        tick();
        flush_i = 0; push_valid_i = 0;
        checks++;
        if (count_o !== 5'd0) begin
            fails++; $display("FAIL flush_prio got cnt=%0d exp 0", count_o);
        end
        tick();
    endtask

    task automatic test_empty();
        chk_valid_i = 1; chk_addr_i = 32'h44;
        tick();
`ifdef CFI_STRICT_UNDERFLOW_EN
        chk_valid_i = 0;
        checks++;
        if ({chk_done_o, chk_ok_o} !== 2'b10) begin
            fails++; $display("FAIL empty_strict got %b exp 10", {chk_done_o, chk_ok_o});
        end
        tick();
        checks++;
        if (to_crash_o !== 1'b1) begin
            fails++; $display("FAIL empty_strict_crash got %b exp 1", to_crash_o);
        end
        apply_reset();
`else
        checks++;
        if ({chk_done_o, chk_ok_o} !== 2'b11 || count_o !== 5'd0) begin
            fails++;
            $display("FAIL empty_lenient got %b cnt=%0d exp 11 cnt=0",
                     {chk_done_o, chk_ok_o}, count_o);
        end
        chk_addr_i = 32'h48; push_valid_i = 1; push_addr_i = 32'h50;
        tick();
        chk_valid_i = 0; push_valid_i = 0; read_index_i = 0;
        checks++;
        if (chk_ok_o !== 1'b1 || count_o !== 5'd1 || read_out_o !== 32'h50) begin
            fails++;
            $display("FAIL empty_push got ok=%b cnt=%0d top=%h exp 1/1/50",
                     chk_ok_o, count_o, read_out_o);
        end
        tick();
`endif
    endtask

    task automatic test_crash();
        do_flush();
        do_push(32'h100);
        chk_valid_i = 1; chk_addr_i = 32'h104;
        tick();
        chk_valid_i = 0;
        checks++;
        if ({chk_done_o, chk_ok_o} !== 2'b10 || count_o !== 5'd0) begin
            fails++;
            $display("FAIL crash_resp got %b cnt=%0d exp 10 cnt=0",
                     {chk_done_o, chk_ok_o}, count_o);
        end
        tick();
        checks++;
        if (to_crash_o !== 1'b1 || chk_done_o !== 1'b0) begin
            fails++;
            $display("FAIL crash_enter got crash=%b done=%b exp 1/0", to_crash_o, chk_done_o);
        end
        do_push(32'h200);
        checks++;
        if (count_o !== 5'd0) begin
            fails++; $display("FAIL crash_push_ignored got cnt=%0d exp 0", count_o);
        end
        do_flush();
        checks++;
        if (to_crash_o !== 1'b1) begin
            fails++; $display("FAIL crash_flush_held got %b exp 1", to_crash_o);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({to_crash_o, overflow_o, chk_done_o, chk_ok_o} !== 4'b0 ||
            count_o !== 5'd0 || read_out_o !== 32'h0) begin
            fails++;
            $display("FAIL async_reset got crash=%b ovf=%b cnt=%0d exp all 0",
                     to_crash_o, overflow_o, count_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_same_cycle();
        test_back_to_back();
        test_enable();
        test_overflow();
        test_flush();
        test_empty();
        test_crash();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
